// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out serializer with valid/ready load.
// Bits advance on shift_en ticks; direction is chosen per word.
// Back-to-back words are sent with no idle gap.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   shift_en     in   bit-advance strobe (ignored while idle)
//   abort        in   synchronous frame kill, beats shift and load
//   load_valid   in   parallel_in / shift_dir are valid
//   load_ready   out  a word can be accepted this cycle (combinational)
//   parallel_in  in   word to serialize
//   shift_dir    in   0 = LSB first, 1 = MSB first; sampled on accept
//   serial_out   out  current serial bit (registered)
//   serial_valid out  serial_out carries a frame bit (registered)
//   busy         out  a frame is in progress
//   done         out  one-cycle pulse after the last bit retires
module piso_serializer #(
   parameter int   WIDTH      = 8,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift_en,
   input  logic             abort,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             shift_dir,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [CNT_W-1:0] r_cnt;
   logic             r_dir;
   logic             r_out;
   logic             r_valid;
   logic             r_done;

   logic             w_last;
   logic             w_accept;

   // Final tick of the frame: the slot where a follow-on word may load.
   assign w_last = (r_state == S_SHIFT) && shift_en && (r_cnt == LAST);

   assign load_ready = !abort && ((r_state == S_IDLE) || w_last);
   assign w_accept   = load_valid && load_ready;

   assign serial_out   = r_out;
   assign serial_valid = r_valid;
   assign busy         = (r_state == S_SHIFT);
   assign done         = r_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_dir   <= 1'b0;
         r_out   <= IDLE_LEVEL;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_out   <= IDLE_LEVEL;
            r_valid <= 1'b0;
         end else if (w_accept) begin
            // Loading on the final tick still retires the old frame.
            r_done  <= w_last;
            r_state <= S_SHIFT;
            r_cnt   <= '0;
            r_dir   <= shift_dir;
            r_valid <= 1'b1;
            if (shift_dir) begin
               r_out   <= parallel_in[WIDTH-1];
               r_shift <= parallel_in << 1;
            end else begin
               r_out   <= parallel_in[0];
               r_shift <= parallel_in >> 1;
            end
         end else if ((r_state == S_SHIFT) && shift_en) begin
            if (r_cnt == LAST) begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_out   <= IDLE_LEVEL;
               r_valid <= 1'b0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_dir) begin
                  r_out   <= r_shift[WIDTH-1];
                  r_shift <= r_shift << 1;
               end else begin
                  r_out   <= r_shift[0];
                  r_shift <= r_shift >> 1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: table vectors, directed corner sequences and random
// traffic against a word/bit-index reference model.
module tb_piso_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         shift_en;
   logic         abort;
   logic         load_valid;
   logic         load_ready;
   logic [W-1:0] parallel_in;
   logic         shift_dir;
   logic         serial_out;
   logic         serial_valid;
   logic         busy;
   logic         done;

   int checks   = 0;
   int failures = 0;

   // Reference model: the word being sent and which frame bit is showing.
   logic         m_active = 1'b0;
   int           m_idx    = 0;
   logic [W-1:0] m_word   = '0;
   logic         m_dir    = 1'b0;
   logic         m_done   = 1'b0;
   logic         m_acc    = 1'b0;

   typedef struct {
      logic         se;
      logic         ab;
      logic         lv;
      logic [W-1:0] pin;
      logic         dir;
      logic         rdy;
      logic         out;
      logic         vld;
      logic         bsy;
      logic         dn;
   } vec_t;

   vec_t tbl [10];

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
      .clk          (clk),
      .reset        (reset),
      .shift_en     (shift_en),
      .abort        (abort),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .parallel_in  (parallel_in),
      .shift_dir    (shift_dir),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .busy         (busy),
      .done         (done)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic m_bit();
      if (!m_active) return 1'b0;
      return m_dir ? m_word[W-1-m_idx] : m_word[m_idx];
   endfunction

   function automatic logic [W-1:0] rev(input logic [W-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = v[W-1-i];
      return r;
   endfunction

   task automatic m_clear();
      m_active = 1'b0;
      m_idx    = 0;
      m_word   = '0;
      m_dir    = 1'b0;
      m_done   = 1'b0;
      m_acc    = 1'b0;
   endtask

   task automatic chk_model();
      chk("serial_out", serial_out, m_bit());
      chk("serial_valid", serial_valid, m_active);
      chk("busy", busy, m_active);
      chk("done", done, m_done);
   endtask

   // One clock: drive at negedge, check ready, update model at posedge.
   task automatic step(input logic se, input logic ab, input logic lv,
                       input logic [W-1:0] pin, input logic dir,
                       output logic rdy);
      logic last;
      logic exp_rdy;
      logic acc;
      @(negedge clk);
      shift_en    = se;
      abort       = ab;
      load_valid  = lv;
      parallel_in = pin;
      shift_dir   = dir;
      #1;
      last    = m_active && se && (m_idx == W - 1);
      exp_rdy = !ab && (!m_active || last);
      rdy     = load_ready;
      chk("load_ready", load_ready, exp_rdy);
      acc = lv && exp_rdy;
      @(posedge clk);
      m_done = !ab && last;
      m_acc  = acc && !ab;
      if (ab) begin
         m_active = 1'b0;
         m_idx    = 0;
      end else if (acc) begin
         m_active = 1'b1;
         m_idx    = 0;
         m_word   = pin;
         m_dir    = dir;
      end else if (last) begin
         m_active = 1'b0;
         m_idx    = 0;
      end else if (m_active && se) begin
         m_idx++;
      end
      #1;
      chk_model();
   endtask

   initial begin
      logic         r;
      logic [15:0]  bits;
      logic [W-1:0] tmp;
      int           nv;
      int           nd;
      int           nr;
      int           nacc;
      logic         drop;

      reset       = 1'b1;
      shift_en    = 1'b0;
      abort       = 1'b0;
      load_valid  = 1'b0;
      parallel_in = '0;
      shift_dir   = 1'b0;

      // Test 1 vectors: A5 LSB first, shift_en every cycle.
      tbl[0] = '{1, 0, 1, 8'hA5, 0, 1, 1, 1, 1, 0};
      tbl[1] = '{1, 0, 0, 8'h00, 0, 0, 0, 1, 1, 0};
      tbl[2] = '{1, 0, 0, 8'h00, 0, 0, 1, 1, 1, 0};
      tbl[3] = '{1, 0, 0, 8'h00, 0, 0, 0, 1, 1, 0};
      tbl[4] = '{1, 0, 0, 8'h00, 0, 0, 0, 1, 1, 0};
      tbl[5] = '{1, 0, 0, 8'h00, 0, 0, 1, 1, 1, 0};
      tbl[6] = '{1, 0, 0, 8'h00, 0, 0, 0, 1, 1, 0};
      tbl[7] = '{1, 0, 0, 8'h00, 0, 0, 1, 1, 1, 0};
      tbl[8] = '{1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 1};
      tbl[9] = '{1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0};

      #12;
      chk("rst_out", serial_out, 1'b0);
      chk("rst_valid", serial_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].se, tbl[i].ab, tbl[i].lv, tbl[i].pin, tbl[i].dir, r);
         chk("t1_rdy", r, tbl[i].rdy);
         chk("t1_out", serial_out, tbl[i].out);
         chk("t1_vld", serial_valid, tbl[i].vld);
         chk("t1_busy", busy, tbl[i].bsy);
         chk("t1_done", done, tbl[i].dn);
      end

      // Test 2: A5 MSB first, one tick every 4 cycles.
      tmp = 8'hA5;
      step(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, r);
      chk("t2_bit", serial_out, tmp[W-1]);
      nr = 0;
      for (int k = 1; k <= 32; k++) begin
         step((k % 4) == 0, 1'b0, 1'b0, 8'h00, 1'b0, r);
         if (k < 32) begin
            if (r) nr++;
            chk("t2_bit", serial_out, tmp[W-1-(k/4)]);
            chk("t2_vld", serial_valid, 1'b1);
         end else begin
            chk("t2_final_rdy", r, 1'b1);
            chk("t2_done", done, 1'b1);
         end
      end
      chk("t2_ready_low", nr, 0);

      // Test 3: back-to-back F0 (LSB first) then 0F (MSB first).
      bits = '0;
      nv   = 0;
      nd   = 0;
      nacc = 0;
      drop = 1'b0;
      for (int i = 0; i < 18; i++) begin
         step(1'b1, 1'b0, nacc < 2, (nacc == 0) ? 8'hF0 : 8'h0F,
              nacc != 0, r);
         if (m_acc) nacc++;
         if (serial_valid) begin
            bits = {bits[14:0], serial_out};
            nv++;
         end else if (i < 16) begin
            drop = 1'b1;
         end
         if (done) nd++;
      end
      chk("t3_bits", bits, 16'h0F0F);
      chk("t3_nvalid", nv, 16);
      chk("t3_ndone", nd, 2);
      chk("t3_no_drop", drop, 1'b0);
      chk("t3_accepts", nacc, 2);

      // Test 4: abort while the third bit of FF is showing.
      step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, r);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, r);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, r);
      chk("t4_third_bit", serial_out, 1'b1);
      step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, r);
      chk("t4_abort_rdy", r, 1'b0);
      chk("t4_vld", serial_valid, 1'b0);
      chk("t4_out", serial_out, 1'b0);
      chk("t4_busy", busy, 1'b0);
      chk("t4_done", done, 1'b0);
      step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, r);
      chk("t4_reload_rdy", r, 1'b1);
      chk("t4_reload_busy", busy, 1'b1);
      chk("t4_reload_out", serial_out, 1'b0);
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, r);
         if (done) nd++;
      end
      chk("t4_reload_done", nd, 1);

      // Test 5: async reset in mid-frame, then a clean 81 frame.
      step(1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, r);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, r);
      load_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("t5_out", serial_out, 1'b0);
      chk("t5_vld", serial_valid, 1'b0);
      chk("t5_busy", busy, 1'b0);
      chk("t5_done", done, 1'b0);
      chk("t5_rdy", load_ready, 1'b1);
      m_clear();
      @(negedge clk);
      #2;
      reset = 1'b0;
      bits = '0;
      step(1'b1, 1'b0, 1'b1, 8'h81, 1'b0, r);
      bits = {bits[14:0], serial_out};
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, r);
         bits = {bits[14:0], serial_out};
      end
      chk("t5_bits", bits[7:0], 8'h81);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, r);
      chk("t5_done", done, 1'b1);

      // Test 6: load attempts and input churn mid-frame are ignored.
      bits = '0;
      nv   = 0;
      nr   = 0;
      step(1'b1, 1'b0, 1'b1, 8'hD4, 1'b0, r);
      bits = {bits[14:0], serial_out};
      nv++;
      for (int i = 0; i < 9; i++) begin
         tmp = 8'h3C ^ 8'(i);
         step(1'b1, 1'b0, (i >= 2) && (i < 5), tmp, i[0], r);
         if ((i >= 2) && (i < 5) && r) nr++;
         if (serial_valid) begin
            bits = {bits[14:0], serial_out};
            nv++;
         end
      end
      chk("t6_no_accept", nr, 0);
      chk("t6_bits", bits[7:0], rev(8'hD4));
      chk("t6_nbits", nv, 8);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
              1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
